// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants, state type and helpers for the round-robin one-hot arbiter
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int PTR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set mask bit at or after ptr, wrapping
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_mask,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_found
);

  logic [PTR_W-1:0] w_idx;

  // Walk the eight positions starting at ptr; the first hit wins, the pointer arithmetic wraps 7 -> 0.
  always_comb begin
    o_pick  = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = i_ptr + PTR_W'(k);
      if (!o_found && i_mask[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - 8-way round-robin arbiter with one-hot grant/ready handshake; option RR_ARB_PENDING_EN
module rr_onehot_arbiter #(
  parameter int N_REQ = 8  // only 8 requesters are supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_ready,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid
);

  import rr_arb_pkg::*;

  state_t           r_state;
  state_t           w_state_next;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_next;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;

  logic             w_handshake;
  logic [N_REQ-1:0] w_accept_mask;
  logic [N_REQ-1:0] w_eff_req;
  logic [PTR_W-1:0] w_ptr_after;
  logic [PTR_W-1:0] w_pick_ptr;
  logic [N_REQ-1:0] w_pick_mask;
  logic [N_REQ-1:0] w_pick;
  logic             w_found;

  assign w_handshake   = (r_state == GRANT) && grant_ready;
  assign w_accept_mask = w_handshake ? r_grant : '0;
  assign w_ptr_after   = onehot_to_idx(r_grant) + PTR_W'(1);

`ifdef RR_ARB_PENDING_EN
  logic [N_REQ-1:0] r_pending;

  assign w_eff_req = req | r_pending;

  // Remember every request seen until that requester's grant is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | req) & ~w_accept_mask;
    end
  end
`else
  assign w_eff_req = req;
`endif

  // On a handshake the next pick searches from the advanced pointer with the accepted bit removed,
  // so one picker serves both the IDLE selection and the back-to-back selection.
  assign w_pick_ptr  = w_handshake ? w_ptr_after : r_ptr;
  assign w_pick_mask = w_eff_req & ~w_accept_mask;

  rr_pick u_pick (
    .i_mask  (w_pick_mask),
    .i_ptr   (w_pick_ptr),
    .o_pick  (w_pick),
    .o_found (w_found)
  );

  // Next-state, next-grant and pointer update; a stalled grant simply holds.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    case (r_state)
      IDLE: begin
        if (en && w_found) begin
          w_grant_next = w_pick;
          w_state_next = GRANT;
        end
      end
      GRANT: begin
        if (w_handshake) begin
          w_ptr_next = w_ptr_after;
          if (en && w_found) begin
            w_grant_next = w_pick;
          end else begin
            w_grant_next = '0;
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_grant_next = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  // State register; reset overrides everything, including a handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_ptr   <= w_ptr_next;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = (r_state == GRANT);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - self-checking bench for rr_onehot_arbiter (both RR_ARB_PENDING_EN builds)
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       grant_ready = 1'b0;
  logic [7:0] grant;
  logic       grant_valid;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RR_ARB_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.N_REQ(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .grant_ready (grant_ready),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Reference model state: holder index, round-robin pointer, remembered requests.
  bit       m_live  = 1'b0;
  bit       m_valid = 1'b0;
  int       m_idx   = 0;
  int       m_ptr   = 0;
  bit [7:0] m_pend  = 8'h00;

  function automatic bit search(input bit [7:0] mask, input int from, output int idx);
    for (int k = 0; k < 8; k++) begin
      if (mask[(from + k) % 8]) begin
        idx = (from + k) % 8;
        return 1'b1;
      end
    end
    idx = 0;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit [7:0] eff;
    bit [7:0] acc;
    int       idx;
    if (rst) begin
      m_live  = 1'b1;
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_pend  = 8'h00;
    end else begin
      eff = PEND ? (req | m_pend) : req;
      acc = 8'h00;
      if (m_valid) begin
        if (grant_ready) begin
          acc   = 8'h01 << m_idx;
          m_ptr = (m_idx + 1) % 8;
          if (en && search(eff & ~acc, m_ptr, idx)) m_idx = idx;
          else m_valid = 1'b0;
        end
      end else if (en && search(eff, m_ptr, idx)) begin
        m_valid = 1'b1;
        m_idx   = idx;
      end
      if (PEND) m_pend = (m_pend | req) & ~acc;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: outputs must equal the model and obey the one-hot/zero rule.
  always @(negedge clk) begin
    logic [7:0] exp_g;
    if (m_live) begin
      exp_g = m_valid ? (8'h01 << m_idx) : 8'h00;
      check("model_grant", grant, exp_g);
      check("model_valid", {7'b0, grant_valid}, {7'b0, m_valid});
      check("onehot_rule", {7'b0, grant_valid ? $onehot(grant) : (grant == 8'h00)}, 8'h01);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] g, input logic v);
    check({name, "_grant"}, grant, g);
    check({name, "_valid"}, {7'b0, grant_valid}, {7'b0, v});
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    expect_out("reset_state", 8'h00, 1'b0);

    // No activity after reset.
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out("idle_no_req", 8'h00, 1'b0);
    end

    // Round-robin alternation between requesters 0 and 2.
    req = 8'h05; grant_ready = 1'b1;
    step(); expect_out("rr_1", 8'h01, 1'b1);
    step(); expect_out("rr_2", 8'h04, 1'b1);
    step(); expect_out("rr_3", 8'h01, 1'b1);
    step(); expect_out("rr_4", 8'h04, 1'b1);
    req = 8'h00;
    step(); expect_out("rr_drain", 8'h00, 1'b0);

    // Backpressure: grant held regardless of req/en changes.
    req = 8'h10; grant_ready = 1'b0;
    step(); expect_out("bp_grant", 8'h10, 1'b1);
    req = 8'h00; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("bp_hold", 8'h10, 1'b1);
    end
    grant_ready = 1'b1;
    step(); expect_out("bp_release", 8'h00, 1'b0);
    // ptr must now be 5: all requests, search starts at bit 5.
    grant_ready = 1'b0; en = 1'b1; req = 8'hFF;
    step(); expect_out("bp_ptr5", 8'h20, 1'b1);
    rst = 1'b1; req = 8'h00;
    step(); expect_out("rst_clear", 8'h00, 1'b0);
    rst = 1'b0;

    // Wrap-around: accept bit 6, then 7 and 0 in turn.
    req = 8'h40; grant_ready = 1'b1;
    step(); expect_out("wrap_g6", 8'h40, 1'b1);
    req = 8'h81;
    step(); expect_out("wrap_g7", 8'h80, 1'b1);
    step(); expect_out("wrap_g0", 8'h01, 1'b1);
    req = 8'h00;
    step(); expect_out("wrap_drain", 8'h00, 1'b0);

    // Short request pulse while grant 0 is stalled.
    req = 8'h01; grant_ready = 1'b0;
    step(); expect_out("pend_g0", 8'h01, 1'b1);
    req = 8'h02;
    step(); expect_out("pend_stall1", 8'h01, 1'b1);
    req = 8'h00;
    step(); expect_out("pend_stall2", 8'h01, 1'b1);
    grant_ready = 1'b1;
    step();
`ifdef RR_ARB_PENDING_EN
    expect_out("pend_next", 8'h02, 1'b1);
`else
    expect_out("pend_lost", 8'h00, 1'b0);
`endif
    step(); expect_out("pend_drain", 8'h00, 1'b0);

    // Enable gating and reset during GRANT.
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0; req = 8'hFF; grant_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("en_off", 8'h00, 1'b0);
    end
    en = 1'b1;
    step(); expect_out("en_on", 8'h01, 1'b1);
    rst = 1'b1; grant_ready = 1'b1;
    step(); expect_out("mid_rst", 8'h00, 1'b0);
    rst = 1'b0; grant_ready = 1'b0;
    step(); expect_out("rst_ptr0", 8'h01, 1'b1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the port en, input, 1 bit: grant enable; 0 means no new grant is issued.
REQ-004 SHALL have the port req, input, 8 bits: raw request lines, bit i = requester i.
REQ-005 SHALL have the port grant_ready, input, 1 bit: the downstream encoder stage accepts the current grant.
REQ-006 SHALL have the port grant, output, 8 bits: one-hot grant vector feeding the downstream 8-to-3 encoder.
REQ-007 SHALL have the port grant_valid, output, 1 bit: grant holds a valid one-hot value.
REQ-008 SHALL have the parameter N_REQ, default 8, requester count; only the value 8 is supported.

Function
REQ-009 SHALL implement a state machine with two states: IDLE (grant_valid=0) and GRANT (grant_valid=1).
REQ-010 SHALL define eff_req as req without RR_ARB_PENDING_EN, and as req | pending with it.
REQ-011 SHALL, in IDLE with en=1 and eff_req!=0, select the first set bit of eff_req at or after index ptr, searching upward and wrapping 7 to 0.
REQ-012 SHALL register that selection into grant and enter GRANT; latency is 1 cycle from request sampled to grant_valid=1.
REQ-013 SHALL always drive grant as exactly one-hot when grant_valid=1 and 8'h00 when grant_valid=0.
REQ-014 SHALL hold grant stable while grant_valid=1 and grant_ready=0, regardless of req or en changes; there is no retraction.
REQ-015 SHALL treat a handshake (grant_valid & grant_ready) as setting ptr to (granted index + 1) mod 8.
REQ-016 SHALL, on the handshake cycle with en=1, pick the next grant from eff_req with the accepted bit masked, searching from the new ptr; if a bit is found it stays in GRANT back-to-back (one grant per cycle), otherwise it returns to IDLE.
REQ-017 SHALL, on a handshake with en=0, return to IDLE.
REQ-018 SHALL leave ptr unchanged when no handshake occurs.
REQ-019 SHALL assert grant_ready=1 in IDLE as having no effect.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, set grant=8'h00, grant_valid=0, ptr=0, pending=8'h00 and state IDLE.
REQ-021 SHALL, when rst is asserted while in GRANT, drop the grant at that edge, with no handshake credited.
REQ-022 SHALL give rst priority over all other inputs in the same cycle.

Configuration
REQ-023 SHALL support the macro RR_ARB_PENDING_EN.
REQ-024 SHALL, with RR_ARB_PENDING_EN defined, implement an 8-bit pending register with pending_next = (pending | req) & ~accepted_mask; a one-cycle request pulse is therefore remembered until granted and accepted.
REQ-025 SHALL, without RR_ARB_PENDING_EN, omit the pending register; requests are level-sensitive and a request withdrawn before selection is lost.

Structure
REQ-026 SHALL place N_REQ=8, PTR_W=3 and the state enum {IDLE, GRANT} in a shared package rr_arb_pkg.
REQ-027 SHALL use one combinational sub-module rr_pick (inputs: 8-bit request mask, 3-bit ptr; outputs: one-hot pick, found flag), instantiated once.

Verification
REQ-028 SHALL verify reset with no activity: rst pulse, then req=8'h00 and en=1 for 10 cycles -> grant_valid=0 and grant=8'h00 throughout.
REQ-029 SHALL verify round-robin alternation: req=8'h05 held, grant_ready=1, en=1 -> grant sequence 8'h01, 8'h04, 8'h01, 8'h04 on consecutive cycles.
REQ-030 SHALL verify backpressure: req=8'h10, grant_ready=0 for 5 cycles -> grant=8'h10 and valid held; then grant_ready=1 -> one handshake, ptr=5.
REQ-031 SHALL verify wrap-around: after bit 6 is accepted (ptr=7), req=8'h81 -> grant 8'h80, then 8'h01.
REQ-032 SHALL verify the pending option: while grant 8'h01 is stalled, pulse req=8'h02 for one cycle, then release the stall -> with RR_ARB_PENDING_EN the next grant is 8'h02; without it grant_valid=0 after the handshake.
REQ-033 SHALL verify enable and mid-grant reset: en=0 with req=8'hFF -> no grant; en=1 gives grant 8'h01, then rst asserted during GRANT -> grant_valid=0 and ptr=0 after that edge.
